regfile_read_stage: RTL and testbench

- Dual-read, single-write register file directly upstream of the operand read mux.
- Its two registered read ports drive the mux's input_data0 and input_data1 words.
- Reads are registered with 1-cycle latency.
- Write-to-read bypass delivers same-cycle write data on a matching read.
- Per-port valid flags tell downstream logic when a fresh operand is present.

---
 rtl/regfile_read_stage.sv | 63 ++++++
 tb/tb_regfile_read_stage.sv | 121 ++++++++++++
 2 files changed

// File: rtl/regfile_read_stage.sv
// Dual-read, single-write register file with registered reads and write bypass.
// Optional macro REGFILE_ZERO_REG_EN hardwires register 0 to zero.
module regfile_read_stage #(
  parameter int word_size = 5,
  parameter int addr_size = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 write_en,
  input  logic [addr_size-1:0] write_addr,
  input  logic [word_size-1:0] write_data,
  input  logic                 read_en0,
  input  logic [addr_size-1:0] read_addr0,
  input  logic                 read_en1,
  input  logic [addr_size-1:0] read_addr1,
  output logic [word_size-1:0] read_data0,
  output logic [word_size-1:0] read_data1,
  output logic                 read_valid0,
  output logic                 read_valid1
);

  localparam int depth = 1 << addr_size;

  logic [word_size-1:0] regs [depth];
  logic                 wr_ok;
  logic [word_size-1:0] src0;
  logic [word_size-1:0] src1;

`ifdef REGFILE_ZERO_REG_EN
  assign wr_ok = write_en & (write_addr != '0);
`else
  assign wr_ok = write_en;
`endif

  // Bypass uses wr_ok so a dropped write to r0 never forwards.
  always_comb begin
    src0 = regs[read_addr0];
    src1 = regs[read_addr1];
`ifdef REGFILE_ZERO_REG_EN
    if (read_addr0 == '0) src0 = '0;
    if (read_addr1 == '0) src1 = '0;
`endif
    if (wr_ok && read_addr0 == write_addr) src0 = write_data;
    if (wr_ok && read_addr1 == write_addr) src1 = write_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) regs[i] <= '0;
      read_data0  <= '0;
      read_data1  <= '0;
      read_valid0 <= 1'b0;
      read_valid1 <= 1'b0;
    end else begin
      if (wr_ok) regs[write_addr] <= write_data;
      read_valid0 <= read_en0;
      read_valid1 <= read_en1;
      if (read_en0) read_data0 <= src0;
      if (read_en1) read_data1 <= src1;
    end
  end

endmodule

// File: tb/tb_regfile_read_stage.sv
// Directed table-driven bench for regfile_read_stage.
// Zero-register checks follow REGFILE_ZERO_REG_EN.
module tb_regfile_read_stage;

  logic       clk = 1'b0;
  logic       rst;
  logic       write_en;
  logic [2:0] write_addr;
  logic [4:0] write_data;
  logic       read_en0;
  logic [2:0] read_addr0;
  logic       read_en1;
  logic [2:0] read_addr1;
  logic [4:0] read_data0;
  logic [4:0] read_data1;
  logic       read_valid0;
  logic       read_valid1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int rst, we, wa, wd, re0, ra0, re1, ra1;
    int d0, v0, d1, v1;
  } vec_t;

  vec_t vecs[$];

  regfile_read_stage #(.word_size(5), .addr_size(3)) dut (
    .clk(clk), .rst(rst),
    .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .read_en0(read_en0), .read_addr0(read_addr0),
    .read_en1(read_en1), .read_addr1(read_addr1),
    .read_data0(read_data0), .read_data1(read_data1),
    .read_valid0(read_valid0), .read_valid1(read_valid1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst        = v.rst[0];
    write_en   = v.we[0];
    write_addr = 3'(v.wa);
    write_data = 5'(v.wd);
    read_en0   = v.re0[0];
    read_addr0 = 3'(v.ra0);
    read_en1   = v.re1[0];
    read_addr1 = 3'(v.ra1);
  endtask

  task automatic step_check(input string tag, input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check({tag, "_d0"}, int'(read_data0), v.d0);
    check({tag, "_v0"}, int'(read_valid0), v.v0);
    check({tag, "_d1"}, int'(read_data1), v.d1);
    check({tag, "_v1"}, int'(read_valid1), v.v1);
  endtask

  int zexp;

  initial begin
    // rst we wa wd re0 ra0 re1 ra1 | d0 v0 d1 v1
    vecs.push_back('{1,1,3,21, 0,0, 0,0,  0,0, 0,0});
    vecs.push_back('{1,1,3,21, 0,0, 0,0,  0,0, 0,0});
    vecs.push_back('{0,0,0,0,  1,3, 0,0,  0,1, 0,0});
    vecs.push_back('{0,1,5,17, 0,0, 0,0,  0,0, 0,0});
    vecs.push_back('{0,0,0,0,  1,5, 1,5, 17,1,17,1});
    vecs.push_back('{0,0,0,0,  0,0, 0,0, 17,0,17,0});
    vecs.push_back('{0,1,2,9,  0,0, 0,0, 17,0,17,0});
    vecs.push_back('{0,1,2,30, 0,0, 1,2, 17,0,30,1});
    vecs.push_back('{0,0,0,0,  1,2, 0,0, 30,1,30,0});
    vecs.push_back('{0,1,4,12, 0,0, 0,0, 30,0,30,0});
    vecs.push_back('{0,0,0,0,  1,4, 0,0, 12,1,30,0});
    vecs.push_back('{0,1,4,7,  0,0, 0,0, 12,0,30,0});
    vecs.push_back('{0,0,0,0,  0,0, 0,0, 12,0,30,0});
    vecs.push_back('{0,0,0,0,  0,0, 0,0, 12,0,30,0});
    vecs.push_back('{0,0,0,0,  1,4, 0,0,  7,1,30,0});
    vecs.push_back('{0,1,6,11, 1,6, 1,6, 11,1,11,1});
    vecs.push_back('{0,0,0,0,  1,5, 1,6, 17,1,11,1});
    vecs.push_back('{0,0,0,0,  1,4, 1,2,  7,1,30,1});
    vecs.push_back('{0,1,1,1,  0,0, 0,0,  7,0,30,0});
    vecs.push_back('{0,1,2,2,  0,0, 0,0,  7,0,30,0});
    vecs.push_back('{0,1,3,3,  0,0, 0,0,  7,0,30,0});
    vecs.push_back('{0,0,0,0,  1,1, 0,0,  1,1,30,0});
    vecs.push_back('{1,0,0,0,  1,2, 0,0,  0,0, 0,0});
    vecs.push_back('{0,0,0,0,  1,3, 0,0,  0,1, 0,0});
    vecs.push_back('{0,1,7,31, 0,0, 0,0,  0,0, 0,0});
    vecs.push_back('{0,0,0,0,  1,0, 1,7,  0,1,31,1});

    foreach (vecs[i]) step_check($sformatf("v%0d", i), vecs[i]);

    // Register 0 write with same-cycle read on both ports, then re-read.
`ifdef REGFILE_ZERO_REG_EN
    zexp = 0;
`else
    zexp = 31;
`endif
    step_check("zero_byp", '{0,1,0,31, 1,0, 1,0, zexp,1,zexp,1});
    step_check("zero_rd",  '{0,0,0,0,  1,0, 0,0, zexp,1,zexp,0});
    step_check("zero_hold",'{0,0,0,0,  0,0, 0,0, zexp,0,zexp,0});

    // Reset while a read and write are both requested: both dropped.
    step_check("rstprio",  '{1,1,6,5,  1,6, 1,6,  0,0, 0,0});
    step_check("rstprio2", '{0,0,0,0,  1,6, 1,7,  0,1, 0,1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
